// File: rtl/ebpf_run_controller.sv
// ebpf_run_controller
// Sequences one eBPF program run on the CPU core. It holds the core in reset
// while idle and loads the entry PC. It gates PC advance on instruction and
// data memory readiness, stops on exit, exception or host abort, and reports
// status, the exception code and run counters to the host side.
//
// Optional feature: define EBPF_RUN_WATCHDOG_EN to end a run that is still in
// RUN after WDOG_CYCLES cycles, reporting status 3 (timeout).
//
// state | meaning
// IDLE  | core held in reset, waiting for a start pulse
// LOAD  | core still in reset, PCContinue loads cpu_first_addr into the PC
// RUN   | program executing, PC advance gated on memory readiness
// DONE  | one-cycle completion pulse, core back in reset

module ebpf_run_controller #(
    parameter int unsigned CNT_W       = 32,
    parameter logic [7:0]  EXIT_OPCODE = 8'h95,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      entry_pc,
    input  logic             abort,
    input  logic             instr_valid,
    input  logic             data_ready,
    input  logic [63:0]      cpu_instruction,
    input  logic             cpu_mem_read,
    input  logic             cpu_mem_write,
    input  logic [4:0]       cpu_exception,
    output logic             cpu_reset,
    output logic [63:0]      cpu_first_addr,
    output logic             pc_continue,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [4:0]       exc_code,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ST_EXIT      = 2'd0;
    localparam logic [1:0] ST_EXCEPTION = 2'd1;
    localparam logic [1:0] ST_ABORT     = 2'd2;
    localparam logic [1:0] ST_TIMEOUT   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef EBPF_RUN_WATCHDOG_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    // Last RUN cycle index allowed before the watchdog fires.
    localparam logic [63:0] WDOG_LAST = 64'(WDOG_CYCLES) - 64'd1;

    state_t           state_q, state_d;
    logic [63:0]      first_addr_q, first_addr_d;
    logic [1:0]       status_q, status_d;
    logic [4:0]       exc_code_q, exc_code_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;

    logic mem_access;
    logic exc_hit;
    logic exit_hit;
    logic wdog_hit;
    logic term;
    logic run_go;

    // Only the opcode byte matters for exit detection.
    logic unused_instr_hi;
    assign unused_instr_hi = ^cpu_instruction[63:8];

    // Termination and advance conditions for the current RUN cycle.
    // With the watchdog disabled the compare is gated by a constant and folds away.
    always_comb begin
        mem_access = cpu_mem_read | cpu_mem_write;
        exc_hit    = (cpu_exception != 5'd0);
        exit_hit   = instr_valid && (cpu_instruction[7:0] == EXIT_OPCODE);
        wdog_hit   = WDOG_EN && (64'(cycle_q) == WDOG_LAST);
        term       = exc_hit | abort | exit_hit | wdog_hit;
        run_go     = instr_valid & (~mem_access | data_ready) & ~term;
    end

    // State register and run bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            first_addr_q <= '0;
            status_q     <= '0;
            exc_code_q   <= '0;
            retired_q    <= '0;
            cycle_q      <= '0;
        end else begin
            state_q      <= state_d;
            first_addr_q <= first_addr_d;
            status_q     <= status_d;
            exc_code_q   <= exc_code_d;
            retired_q    <= retired_d;
            cycle_q      <= cycle_d;
        end
    end

    // Next-state, register updates and core-facing controls.
    always_comb begin
        state_d      = state_q;
        first_addr_d = first_addr_q;
        status_d     = status_q;
        exc_code_d   = exc_code_q;
        retired_d    = retired_q;
        cycle_d      = cycle_q;
        cpu_reset    = 1'b1;
        pc_continue  = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    first_addr_d = entry_pc;
                    status_d     = ST_EXIT;
                    exc_code_d   = 5'd0;
                    retired_d    = '0;
                    cycle_d      = '0;
                end
            end
            S_LOAD: begin
                pc_continue = 1'b1;
                busy        = 1'b1;
                state_d     = S_RUN;
            end
            S_RUN: begin
                cpu_reset   = 1'b0;
                busy        = 1'b1;
                pc_continue = run_go;
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + CNT_ONE;
                end
                if (run_go && (retired_q != '1)) begin
                    retired_d = retired_q + CNT_ONE;
                end
                if (term) begin
                    state_d = S_DONE;
                    if (exc_hit) begin
                        status_d   = ST_EXCEPTION;
                        exc_code_d = cpu_exception;
                    end else if (abort) begin
                        status_d = ST_ABORT;
                    end else if (exit_hit) begin
                        status_d = ST_EXIT;
                    end else begin
                        status_d = ST_TIMEOUT;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cpu_first_addr = first_addr_q;
    assign status         = status_q;
    assign exc_code       = exc_code_q;
    assign retired_count  = retired_q;
    assign cycle_count    = cycle_q;

endmodule

// File: tb/tb_ebpf_run_controller.sv
// Bench for ebpf_run_controller: a directed cycle table, hand-written
// long-run sequences, and randomized runs checked against a run-level model.

module tb_ebpf_run_controller;

    localparam int WDOG = 10;

`ifdef EBPF_RUN_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] entry_pc;
    logic        abort;
    logic        instr_valid;
    logic        data_ready;
    logic [63:0] cpu_instruction;
    logic        cpu_mem_read;
    logic        cpu_mem_write;
    logic [4:0]  cpu_exception;

    logic        cpu_reset;
    logic [63:0] cpu_first_addr;
    logic        pc_continue;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic [4:0]  exc_code;
    logic [31:0] retired_count;
    logic [31:0] cycle_count;

    logic        sat_unused_cpu_reset;
    logic [63:0] sat_unused_first;
    logic        sat_unused_pcc;
    logic        sat_unused_busy;
    logic        sat_unused_done;
    logic [1:0]  sat_unused_status;
    logic [4:0]  sat_unused_exc;
    logic [2:0]  sat_retired;
    logic [2:0]  sat_cycles;

    ebpf_run_controller #(.CNT_W(32), .EXIT_OPCODE(8'h95), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset), .start(start), .entry_pc(entry_pc), .abort(abort),
        .instr_valid(instr_valid), .data_ready(data_ready), .cpu_instruction(cpu_instruction),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write), .cpu_exception(cpu_exception),
        .cpu_reset(cpu_reset), .cpu_first_addr(cpu_first_addr), .pc_continue(pc_continue),
        .busy(busy), .done(done), .status(status), .exc_code(exc_code),
        .retired_count(retired_count), .cycle_count(cycle_count)
    );

    // Narrow-counter instance sharing the same stimulus, used to observe saturation.
    ebpf_run_controller #(.CNT_W(3)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .entry_pc(entry_pc), .abort(abort),
        .instr_valid(instr_valid), .data_ready(data_ready), .cpu_instruction(cpu_instruction),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write), .cpu_exception(cpu_exception),
        .cpu_reset(sat_unused_cpu_reset), .cpu_first_addr(sat_unused_first),
        .pc_continue(sat_unused_pcc), .busy(sat_unused_busy), .done(sat_unused_done),
        .status(sat_unused_status), .exc_code(sat_unused_exc),
        .retired_count(sat_retired), .cycle_count(sat_cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic st, input logic [63:0] pc, input logic ab,
                         input logic iv, input logic dr, input logic [63:0] instr,
                         input logic mr, input logic mw, input logic [4:0] ex);
        reset           = rst;
        start           = st;
        entry_pc        = pc;
        abort           = ab;
        instr_valid     = iv;
        data_ready      = dr;
        cpu_instruction = instr;
        cpu_mem_read    = mr;
        cpu_mem_write   = mw;
        cpu_exception   = ex;
    endtask

    task automatic drive_quiet(input logic st, input logic ab);
        drive(1'b0, st, 64'd0, ab, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 5'd0);
    endtask

    // One directed cycle: inputs applied this cycle and outputs expected in it.
    typedef struct {
        logic        rst, st;
        logic [63:0] pc;
        logic        ab, iv, dr;
        logic [7:0]  op;
        logic        mr, mw;
        logic [4:0]  ex;
        logic        e_crst, e_pcc, e_busy, e_done;
        logic [1:0]  e_st;
        logic [4:0]  e_exc;
        logic [31:0] e_ret, e_cyc;
        logic [63:0] e_first;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic st, input logic [63:0] pc,
                                input logic ab, input logic iv, input logic dr, input logic [7:0] op,
                                input logic mr, input logic mw, input logic [4:0] ex,
                                input logic e_crst, input logic e_pcc, input logic e_busy,
                                input logic e_done, input logic [1:0] e_st, input logic [4:0] e_exc,
                                input int e_ret, input int e_cyc, input logic [63:0] e_first);
        vec_t v;
        v.rst = rst; v.st = st; v.pc = pc; v.ab = ab; v.iv = iv; v.dr = dr; v.op = op;
        v.mr = mr; v.mw = mw; v.ex = ex;
        v.e_crst = e_crst; v.e_pcc = e_pcc; v.e_busy = e_busy; v.e_done = e_done;
        v.e_st = e_st; v.e_exc = e_exc; v.e_ret = e_ret; v.e_cyc = e_cyc; v.e_first = e_first;
        vecs.push_back(v);
    endfunction

    // One RUN cycle of randomized core-side stimulus.
    typedef struct {
        logic        st, ab, iv, dr, mr, mw;
        logic [4:0]  ex;
        logic [63:0] instr;
    } cyc_t;

    function automatic cyc_t rand_cycle(input bit force_exit);
        cyc_t c;
        c.st    = ($urandom_range(0, 3) == 0);
        c.iv    = ($urandom_range(0, 3) != 0);
        c.mr    = ($urandom_range(0, 3) == 0);
        c.mw    = !c.mr && ($urandom_range(0, 7) == 0);
        c.dr    = 1'($urandom_range(0, 1));
        c.ab    = ($urandom_range(0, 39) == 0);
        c.ex    = ($urandom_range(0, 39) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        c.instr = {$urandom, $urandom};
        if (c.instr[7:0] == 8'h95) c.instr[7:0] = 8'h07;
        if (force_exit || $urandom_range(0, 9) == 0) c.instr[7:0] = 8'h95;
        if (force_exit) c.iv = 1'b1;
        return c;
    endfunction

    cyc_t        prog[$];
    bit          exp_pcc[$];
    int          t_end;
    int          exp_ret;
    logic [1:0]  exp_status;
    logic [4:0]  exp_exc;
    logic [63:0] run_pc;

    // Run-level reference: walk the program until the first terminating cycle.
    task automatic model_run();
        bit stop;
        exp_pcc.delete();
        exp_ret    = 0;
        exp_status = 2'd0;
        exp_exc    = 5'd0;
        t_end      = prog.size() - 1;
        stop       = 1'b0;
        for (int k = 0; k < prog.size() && !stop; k++) begin
            bit is_exc, is_exit, is_wd, go;
            is_exc  = (prog[k].ex != 5'd0);
            is_exit = prog[k].iv && (prog[k].instr[7:0] == 8'h95);
            is_wd   = WD_EN && (k == WDOG - 1);
            if (is_exc || prog[k].ab || is_exit || is_wd) begin
                t_end = k;
                stop  = 1'b1;
                exp_pcc.push_back(1'b0);
                if (is_exc) begin
                    exp_status = 2'd1;
                    exp_exc    = prog[k].ex;
                end else if (prog[k].ab) begin
                    exp_status = 2'd2;
                end else if (is_exit) begin
                    exp_status = 2'd0;
                end else begin
                    exp_status = 2'd3;
                end
            end else begin
                go = prog[k].iv && (!(prog[k].mr || prog[k].mw) || prog[k].dr);
                exp_pcc.push_back(go);
                if (go) exp_ret++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 500000");
        $fatal(1, "time limit");
    end

    initial begin
        // ---- directed table ----
        // exit after 3 ALU ops from entry 16
        add(0,1,16, 0,1,0,8'h07,0,0,0, 1,0,0,0, 0,0, 0,0, 0);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 1,1,1,0, 0,0, 0,0, 16);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 0,1,1,0, 0,0, 0,0, 16);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 0,1,1,0, 0,0, 1,1, 16);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 0,1,1,0, 0,0, 2,2, 16);
        add(0,0,0,  0,1,0,8'h95,0,0,0, 0,0,1,0, 0,0, 3,3, 16);
        add(0,0,0,  0,0,0,8'h00,0,0,0, 1,0,0,1, 0,0, 3,4, 16);
        add(0,0,0,  0,0,0,8'h00,0,0,0, 1,0,0,0, 0,0, 3,4, 16);
        // load stalled 4 cycles on data_ready
        add(0,1,32, 0,0,0,8'h00,0,0,0, 1,0,0,0, 0,0, 3,4, 16);
        add(0,0,0,  0,1,0,8'h79,1,0,0, 1,1,1,0, 0,0, 0,0, 32);
        for (int k = 0; k < 4; k++)
            add(0,0,0, 0,1,0,8'h79,1,0,0, 0,0,1,0, 0,0, 0,k, 32);
        add(0,0,0,  0,1,1,8'h79,1,0,0, 0,1,1,0, 0,0, 0,4, 32);
        add(0,0,0,  0,1,0,8'h95,0,0,0, 0,0,1,0, 0,0, 1,5, 32);
        add(0,0,0,  0,0,0,8'h00,0,0,0, 1,0,0,1, 0,0, 1,6, 32);
        add(0,0,0,  0,0,0,8'h00,0,0,0, 1,0,0,0, 0,0, 1,6, 32);
        // exception with abort on 2nd RUN cycle; abort in LOAD/DONE ignored
        add(0,1,48, 0,0,0,8'h00,0,0,0, 1,0,0,0, 0,0, 1,6, 32);
        add(0,0,0,  1,1,0,8'h07,0,0,0, 1,1,1,0, 0,0, 0,0, 48);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 0,1,1,0, 0,0, 0,0, 48);
        add(0,0,0,  1,1,0,8'h07,0,0,3, 0,0,1,0, 0,0, 1,1, 48);
        add(0,0,0,  1,0,0,8'h00,0,0,0, 1,0,0,1, 1,3, 1,2, 48);
        add(0,0,0,  0,0,0,8'h00,0,0,0, 1,0,0,0, 1,3, 1,2, 48);
        // abort in RUN, restart without reset, start ignored in RUN, reset mid-run
        add(0,1,100,0,0,0,8'h00,0,0,0, 1,0,0,0, 1,3, 1,2, 48);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 1,1,1,0, 0,0, 0,0, 100);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 0,1,1,0, 0,0, 0,0, 100);
        add(0,0,0,  1,1,0,8'h07,0,0,0, 0,0,1,0, 0,0, 1,1, 100);
        add(0,0,0,  0,0,0,8'h00,0,0,0, 1,0,0,1, 2,0, 1,2, 100);
        add(0,1,200,0,0,0,8'h00,0,0,0, 1,0,0,0, 2,0, 1,2, 100);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 1,1,1,0, 0,0, 0,0, 200);
        add(0,1,999,0,1,0,8'h07,0,0,0, 0,1,1,0, 0,0, 0,0, 200);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 0,1,1,0, 0,0, 1,1, 200);
        add(1,0,0,  0,1,0,8'h07,0,0,0, 0,1,1,0, 0,0, 2,2, 200);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 1,0,0,0, 0,0, 0,0, 0);
        add(0,0,0,  0,1,0,8'h07,0,0,0, 1,0,0,0, 0,0, 0,0, 0);

        // ---- reset values ----
        drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 5'd0);
        repeat (3) tick();
        check("rst.cpu_reset", cpu_reset, 1);
        check("rst.pc_continue", pc_continue, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.status", status, 0);
        check("rst.exc_code", exc_code, 0);
        check("rst.retired", retired_count, 0);
        check("rst.cycles", cycle_count, 0);
        check("rst.first_addr", cpu_first_addr, 0);

        // ---- table ----
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rst, v.st, v.pc, v.ab, v.iv, v.dr, {56'd0, v.op}, v.mr, v.mw, v.ex);
            #2;
            check($sformatf("v%0d.cpu_reset", i), cpu_reset, v.e_crst);
            check($sformatf("v%0d.pc_continue", i), pc_continue, v.e_pcc);
            check($sformatf("v%0d.busy", i), busy, v.e_busy);
            check($sformatf("v%0d.done", i), done, v.e_done);
            check($sformatf("v%0d.status", i), status, v.e_st);
            check($sformatf("v%0d.exc_code", i), exc_code, v.e_exc);
            check($sformatf("v%0d.retired", i), retired_count, v.e_ret);
            check($sformatf("v%0d.cycles", i), cycle_count, v.e_cyc);
            check($sformatf("v%0d.first_addr", i), cpu_first_addr, v.e_first);
            tick();
        end

        // ---- infinite loop (ja -1) ----
        drive(1'b0, 1'b1, 64'd8, 1'b0, 1'b1, 1'b0, 64'h05, 1'b0, 1'b0, 5'd0);
        tick();
        drive(1'b0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 64'h05, 1'b0, 1'b0, 5'd0);
        tick();
`ifdef EBPF_RUN_WATCHDOG_EN
        for (int k = 0; k < WDOG; k++) begin
            #2;
            check($sformatf("wd.pcc%0d", k), pc_continue, (k < WDOG - 1) ? 1 : 0);
            tick();
        end
        #2;
        check("wd.done", done, 1);
        check("wd.status", status, 3);
        check("wd.cycles", cycle_count, WDOG);
        check("wd.retired", retired_count, WDOG - 1);
`else
        repeat (1000) tick();
        #2;
        check("loop.busy", busy, 1);
        check("loop.done", done, 0);
        check("loop.cycles", cycle_count, 1000);
        check("loop.retired", retired_count, 1000);
        abort = 1'b1;
        #1;
        check("loop.abort_pcc", pc_continue, 0);
        tick();
        abort = 1'b0;
        #2;
        check("loop.done", done, 1);
        check("loop.status", status, 2);
        check("loop.cycles_end", cycle_count, 1001);
`endif
        check("sat.cycles", sat_cycles, 7);
        check("sat.retired", sat_retired, 7);

        // ---- randomized runs against the run-level model ----
        drive(1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 5'd0);
        repeat (2) tick();
        for (int r = 0; r < 60; r++) begin
            int len;
            prog.delete();
            len = $urandom_range(1, 25);
            for (int k = 0; k < len; k++) prog.push_back(rand_cycle(k == len - 1));
            model_run();
            repeat ($urandom_range(0, 2)) begin
                drive_quiet(1'b0, 1'($urandom_range(0, 1)));
                tick();
            end
            run_pc = {$urandom, $urandom};
            drive(1'b0, 1'b1, run_pc, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 64'd0, 1'b0, 1'b0, 5'd0);
            #2;
            check($sformatf("r%0d.idle_busy", r), busy, 0);
            tick();
            drive(1'b0, 1'($urandom_range(0, 1)), 64'd0, 1'($urandom_range(0, 1)), 1'b1, 1'b0,
                  64'h07, 1'b0, 1'b0, 5'd0);
            #2;
            check($sformatf("r%0d.load_pcc", r), pc_continue, 1);
            check($sformatf("r%0d.first_addr", r), cpu_first_addr, run_pc);
            tick();
            for (int k = 0; k <= t_end; k++) begin
                drive(1'b0, prog[k].st, 64'd0, prog[k].ab, prog[k].iv, prog[k].dr,
                      prog[k].instr, prog[k].mr, prog[k].mw, prog[k].ex);
                #2;
                check($sformatf("r%0d.c%0d.pcc", r, k), pc_continue, exp_pcc[k]);
                tick();
            end
            drive_quiet(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            #2;
            check($sformatf("r%0d.done", r), done, 1);
            check($sformatf("r%0d.status", r), status, exp_status);
            check($sformatf("r%0d.exc_code", r), exc_code, exp_exc);
            check($sformatf("r%0d.retired", r), retired_count, exp_ret);
            check($sformatf("r%0d.cycles", r), cycle_count, t_end + 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
